// File: rtl/matrix_scan_if.sv
// Write port and LED-matrix drive bundle for matrix_scan.
// The game FSM (master) writes rows; the scanner (slave) drives the matrix.
interface matrix_scan_if;
    logic       wr_strobe;
    logic [2:0] wr_row;
    logic [7:0] wr_val;
    logic       clr;
    logic       blink;
    logic [7:0] row_n;
    logic [7:0] col;
    logic       frame_start;

    modport master (
        output wr_strobe, wr_row, wr_val, clr, blink,
        input  row_n, col, frame_start
    );

    modport slave (
        input  wr_strobe, wr_row, wr_val, clr, blink,
        output row_n, col, frame_start
    );
endinterface

// File: rtl/matrix_scan.sv
// 8x8 row store plus one-row-at-a-time LED multiplexer with blanking between rows.
// Optional blink gating is built only when MATRIX_SCAN_BLINK_EN is defined.
module matrix_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 25000000
) (
    input logic           clk,
    input logic           reset_n,
    matrix_scan_if.slave  bus
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptrNext;
    logic             w_enterDrive;
    logic             w_enterBlank;
    logic [7:0]       r_mem [8];
    logic [7:0]       w_snapshot;
    logic [7:0]       r_rowN;
    logic [7:0]       r_col;
    logic             r_frameStart;

    // Clear wins over a simultaneous write; the snapshot below reads pre-edge contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.clr) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.wr_strobe) begin
            r_mem[bus.wr_row] <= bus.wr_val;
        end
    end

`ifdef MATRIX_SCAN_BLINK_EN
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_DIV - 1);

    logic [BL_W-1:0] r_blinkCnt;
    logic            r_blinkOff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blinkCnt <= '0;
            r_blinkOff <= 1'b0;
        end else if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt <= '0;
            r_blinkOff <= ~r_blinkOff;
        end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    assign w_snapshot = (bus.blink && r_blinkOff) ? 8'h00 : r_mem[r_ptr];
`else
    assign w_snapshot = r_mem[r_ptr];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_ptr   <= w_ptrNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt + 1'b1;
        w_ptrNext    = r_ptr;
        w_enterDrive = 1'b0;
        w_enterBlank = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_stateNext  = ST_DRIVE;
                    w_cntNext    = '0;
                    w_enterDrive = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == DRIVE_LAST) begin
                    w_stateNext  = ST_BLANK;
                    w_cntNext    = '0;
                    w_ptrNext    = r_ptr + 3'd1;
                    w_enterBlank = 1'b1;
                end
            end
            default: begin
                w_stateNext = ST_BLANK;
                w_cntNext   = '0;
            end
        endcase
    end

    // Row data is latched once on DRIVE entry and held for the whole visit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rowN       <= 8'hFF;
            r_col        <= 8'h00;
            r_frameStart <= 1'b0;
        end else begin
            r_frameStart <= 1'b0;
            if (w_enterDrive) begin
                r_rowN       <= ~(8'h01 << r_ptr);
                r_col        <= w_snapshot;
                r_frameStart <= (r_ptr == 3'd0);
            end else if (w_enterBlank) begin
                r_rowN <= 8'hFF;
                r_col  <= 8'h00;
            end
        end
    end

    assign bus.row_n       = r_rowN;
    assign bus.col         = r_col;
    assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: scenario tasks plus a timing-arithmetic reference model.
// Build with MATRIX_SCAN_BLINK_EN defined to exercise the blink gating.
module tb_matrix_scan;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int BLINK_DIV    = 48;
    localparam int ROW_PERIOD   = SCAN_DIV + BLANK_CYCLES;
    localparam int FRAME        = 8 * ROW_PERIOD;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    matrix_scan_if bus ();

    matrix_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the display position is pure arithmetic on edges since reset.
    logic [7:0] modelMem [8];
    int         edgeCount;
    logic [7:0] expRowN;
    logic [7:0] expCol;
    logic       expFs;

    function automatic int phaseOf(int n);
        return (n + ROW_PERIOD - BLANK_CYCLES) % ROW_PERIOD;
    endfunction

    function automatic int rowOf(int n);
        return ((n + ROW_PERIOD - BLANK_CYCLES) / ROW_PERIOD - 1) % 8;
    endfunction

    function automatic logic blinkOff(int n, logic req);
`ifdef MATRIX_SCAN_BLINK_EN
        return req && ((((n - 1) / BLINK_DIV) % 2) == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int rowFromN(logic [7:0] rn);
        for (int i = 0; i < 8; i++) begin
            if (rn[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgeCount <= 0;
            for (int i = 0; i < 8; i++) modelMem[i] <= 8'h00;
            expRowN <= 8'hFF;
            expCol  <= 8'h00;
            expFs   <= 1'b0;
        end else begin
            edgeCount <= edgeCount + 1;
            expFs     <= 1'b0;
            if (phaseOf(edgeCount + 1) == 0) begin
                expRowN <= ~(8'h01 << rowOf(edgeCount + 1));
                expCol  <= blinkOff(edgeCount + 1, bus.blink) ? 8'h00 : modelMem[rowOf(edgeCount + 1)];
                expFs   <= (rowOf(edgeCount + 1) == 0);
            end else if (phaseOf(edgeCount + 1) >= SCAN_DIV) begin
                expRowN <= 8'hFF;
                expCol  <= 8'h00;
            end
            if (bus.clr) begin
                for (int i = 0; i < 8; i++) modelMem[i] <= 8'h00;
            end else if (bus.wr_strobe) begin
                modelMem[bus.wr_row] <= bus.wr_val;
            end
        end
    end

    task automatic idle_inputs();
        bus.wr_strobe = 1'b0;
        bus.wr_row    = 3'd0;
        bus.wr_val    = 8'h00;
        bus.clr       = 1'b0;
    endtask

    task automatic write_row(input logic [2:0] row, input logic [7:0] val);
        @(negedge clk);
        bus.wr_strobe = 1'b1;
        bus.wr_row    = row;
        bus.wr_val    = val;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        int fsCount;
        fsCount = 0;
        idle_inputs();
        bus.blink = 1'b0;
        reset_n   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.row_n, bus.col, bus.frame_start} !== {8'hFF, 8'h00, 1'b0})
                begin errors++; $display("[TB] FAIL reset_hold row_n=%h col=%h fs=%b expected FF 00 0", bus.row_n, bus.col, bus.frame_start); end
        end
        reset_n = 1'b1;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (bus.row_n !== expRowN || bus.col !== expCol || bus.frame_start !== expFs)
                begin errors++; $display("[TB] FAIL reset_model c=%0d row_n=%h/%h col=%h/%h fs=%b/%b", c, bus.row_n, expRowN, bus.col, expCol, bus.frame_start, expFs); end
            if (bus.frame_start) fsCount++;
            if (c == 1) begin
                checks++;
                if (bus.row_n !== 8'hFF) begin errors++; $display("[TB] FAIL reset_blank row_n=%h expected FF", bus.row_n); end
            end
            if (c == 2) begin
                checks++;
                if ({bus.row_n, bus.col, bus.frame_start} !== {8'hFE, 8'h00, 1'b1})
                    begin errors++; $display("[TB] FAIL first_drive row_n=%h col=%h fs=%b expected FE 00 1", bus.row_n, bus.col, bus.frame_start); end
            end
        end
        checks++;
        if (fsCount !== 1) begin errors++; $display("[TB] FAIL reset_fs_count got %0d expected 1", fsCount); end
    endtask

    task automatic test_rows();
        int waited;
        logic [7:0] want;
        write_row(3'd0, 8'hE0);
        write_row(3'd7, 8'h07);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.frame_start !== 1'b1 && waited < 2 * FRAME);
        checks++;
        if (bus.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL rows_wait_frame got timeout expected frame_start"); end
        for (int c = 1; c <= 2 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (bus.row_n !== expRowN || bus.col !== expCol || bus.frame_start !== expFs)
                begin errors++; $display("[TB] FAIL rows_model c=%0d row_n=%h/%h col=%h/%h fs=%b/%b", c, bus.row_n, expRowN, bus.col, expCol, bus.frame_start, expFs); end
            case (bus.row_n)
                8'hFE:   want = 8'hE0;
                8'h7F:   want = 8'h07;
                default: want = 8'h00;
            endcase
            checks++;
            if (bus.col !== want) begin errors++; $display("[TB] FAIL rows_col row_n=%h col=%h expected %h", bus.row_n, bus.col, want); end
            checks++;
            if (bus.frame_start !== (c % FRAME == 0))
                begin errors++; $display("[TB] FAIL rows_frame_period c=%0d fs=%b expected %b", c, bus.frame_start, (c % FRAME == 0)); end
        end
    endtask

    task automatic test_snapshot();
        int waited;
        logic leftRow;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.row_n !== 8'hF7 && waited < 2 * FRAME);
        checks++;
        if (bus.row_n !== 8'hF7) begin errors++; $display("[TB] FAIL snap_wait_row3 got %h expected F7", bus.row_n); end
        bus.wr_strobe = 1'b1;
        bus.wr_row    = 3'd3;
        bus.wr_val    = 8'hFF;
        @(negedge clk);
        idle_inputs();
        while (bus.row_n === 8'hF7) begin
            checks++;
            if (bus.col !== 8'h00) begin errors++; $display("[TB] FAIL snap_same_visit col=%h expected 00", bus.col); end
            @(negedge clk);
        end
        leftRow = 1'b1;
        waited  = 0;
        while (bus.row_n !== 8'hF7 && waited < 2 * FRAME) begin
            checks++;
            if (bus.row_n !== expRowN || bus.col !== expCol)
                begin errors++; $display("[TB] FAIL snap_model row_n=%h/%h col=%h/%h", bus.row_n, expRowN, bus.col, expCol); end
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!(leftRow && bus.row_n === 8'hF7 && bus.col === 8'hFF))
            begin errors++; $display("[TB] FAIL snap_next_visit row_n=%h col=%h expected F7 FF", bus.row_n, bus.col); end
    endtask

    task automatic test_clear();
        write_row(3'd2, 8'h55);
        @(negedge clk);
        bus.clr       = 1'b1;
        bus.wr_strobe = 1'b1;
        bus.wr_row    = 3'd2;
        bus.wr_val    = 8'hAA;
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < FRAME + ROW_PERIOD; c++) begin
            @(negedge clk);
            checks++;
            if (bus.row_n !== expRowN || bus.col !== expCol)
                begin errors++; $display("[TB] FAIL clear_model row_n=%h/%h col=%h/%h", bus.row_n, expRowN, bus.col, expCol); end
            if (c >= ROW_PERIOD) begin
                checks++;
                if (bus.col !== 8'h00) begin errors++; $display("[TB] FAIL clear_col row_n=%h col=%h expected 00", bus.row_n, bus.col); end
            end
        end
    endtask

    task automatic test_scan_timing();
        logic prevDrive;
        logic started;
        logic wrapSeen;
        int   runLen;
        int   prevRow;
        int   waited;
        prevDrive = 1'b0;
        started   = 1'b0;
        wrapSeen  = 1'b0;
        runLen    = 0;
        prevRow   = -1;
        for (int c = 0; c < 2 * FRAME + ROW_PERIOD; c++) begin
            @(negedge clk);
            checks++;
            if ($countones(~bus.row_n) > 1) begin errors++; $display("[TB] FAIL onehot row_n=%h expected at most one low bit", bus.row_n); end
            if ((bus.row_n !== 8'hFF) != prevDrive) begin
                if (started) begin
                    checks++;
                    if (runLen !== (prevDrive ? SCAN_DIV : BLANK_CYCLES))
                        begin errors++; $display("[TB] FAIL run_length drive=%b got %0d expected %0d", prevDrive, runLen, prevDrive ? SCAN_DIV : BLANK_CYCLES); end
                end
                if (bus.row_n !== 8'hFF) begin
                    if (prevRow >= 0) begin
                        checks++;
                        if (rowFromN(bus.row_n) !== (prevRow + 1) % 8)
                            begin errors++; $display("[TB] FAIL row_order got %0d expected %0d", rowFromN(bus.row_n), (prevRow + 1) % 8); end
                        if (prevRow == 7 && rowFromN(bus.row_n) == 0) wrapSeen = 1'b1;
                    end
                    prevRow = rowFromN(bus.row_n);
                end
                started   = 1'b1;
                prevDrive = (bus.row_n !== 8'hFF);
                runLen    = 1;
            end else begin
                runLen++;
            end
        end
        checks++;
        if (!wrapSeen) begin errors++; $display("[TB] FAIL ptr_wrap got no 7->0 expected wrap"); end

        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.row_n === 8'hFF && waited < 4 * ROW_PERIOD);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.row_n, bus.col, bus.frame_start} !== {8'hFF, 8'h00, 1'b0})
            begin errors++; $display("[TB] FAIL async_reset row_n=%h col=%h fs=%b expected FF 00 0", bus.row_n, bus.col, bus.frame_start); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.row_n !== 8'hFF) begin errors++; $display("[TB] FAIL restart_blank row_n=%h expected FF", bus.row_n); end
        @(negedge clk);
        checks++;
        if ({bus.row_n, bus.frame_start} !== {8'hFE, 1'b1})
            begin errors++; $display("[TB] FAIL restart_row0 row_n=%h fs=%b expected FE 1", bus.row_n, bus.frame_start); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 8 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (bus.row_n !== expRowN || bus.col !== expCol || bus.frame_start !== expFs)
                begin errors++; $display("[TB] FAIL random_model c=%0d row_n=%h/%h col=%h/%h fs=%b/%b", c, bus.row_n, expRowN, bus.col, expCol, bus.frame_start, expFs); end
            bus.wr_strobe = ($urandom_range(0, 2) == 0);
            bus.wr_row    = 3'($urandom_range(0, 7));
            bus.wr_val    = 8'($urandom_range(0, 255));
            bus.clr       = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_blink();
        int zeroCnt;
        int fullCnt;
        zeroCnt = 0;
        fullCnt = 0;
        for (int r = 0; r < 8; r++) write_row(3'(r), 8'hFF);
        bus.blink = 1'b1;
        for (int c = 0; c < 5 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (bus.row_n !== expRowN || bus.col !== expCol)
                begin errors++; $display("[TB] FAIL blink_model c=%0d row_n=%h/%h col=%h/%h", c, bus.row_n, expRowN, bus.col, expCol); end
            if (c >= FRAME && bus.row_n !== 8'hFF) begin
                if (bus.col === 8'h00) zeroCnt++;
                if (bus.col === 8'hFF) fullCnt++;
            end
        end
        checks++;
`ifdef MATRIX_SCAN_BLINK_EN
        if (zeroCnt == 0 || fullCnt == 0)
            begin errors++; $display("[TB] FAIL blink_phases got off=%0d on=%0d expected both nonzero", zeroCnt, fullCnt); end
`else
        if (zeroCnt != 0)
            begin errors++; $display("[TB] FAIL blink_ignored got off=%0d expected 0", zeroCnt); end
`endif
        bus.blink = 1'b0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (bus.row_n !== expRowN || bus.col !== expCol)
                begin errors++; $display("[TB] FAIL noblink_model c=%0d row_n=%h/%h col=%h/%h", c, bus.row_n, expRowN, bus.col, expCol); end
            if (c >= FRAME && bus.row_n !== 8'hFF) begin
                checks++;
                if (bus.col !== 8'hFF) begin errors++; $display("[TB] FAIL noblink_col row_n=%h col=%h expected FF", bus.row_n, bus.col); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.blink = 1'b0;
        test_reset();
        test_rows();
        test_snapshot();
        test_clear();
        test_scan_timing();
        test_random();
        test_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
